// File: rtl/squash_input_conditioner_if.sv
// squash_input_conditioner_if: pad-side keys, gpio flag and conditioned game-core outputs
// master: raw active-low pads and gpio_ready out, conditioned levels/strobes/resets in
// slave : the conditioner side of the same bundle
interface squash_input_conditioner_if;
    logic ext_reset_n;
    logic pause_n;
    logic new_game_n;
    logic up_key_n;
    logic down_key_n;
    logic gpio_ready;
    logic design_reset;
    logic pause_o;
    logic new_game_o;
    logic up_o;
    logic down_o;
    logic pause_pulse;
    logic new_game_pulse;
    logic debug_design_reset;
    logic debug_gpio_ready;
    modport master (
        output ext_reset_n, pause_n, new_game_n, up_key_n, down_key_n, gpio_ready,
        input  design_reset, pause_o, new_game_o, up_o, down_o,
        input  pause_pulse, new_game_pulse, debug_design_reset, debug_gpio_ready
    );
    modport slave (
        input  ext_reset_n, pause_n, new_game_n, up_key_n, down_key_n, gpio_ready,
        output design_reset, pause_o, new_game_o, up_o, down_o,
        output pause_pulse, new_game_pulse, debug_design_reset, debug_gpio_ready
    );
endinterface

// File: rtl/squash_input_conditioner.sv
// squash_input_conditioner: sync/debounce squash pads and sequence the game-core reset
// wb_clk_i/wb_rst_i: clock and synchronous active-high reset
// io (slave): raw active-low pads + gpio_ready in; design_reset, key levels, press strobes, debug copies out
// SQUASH_DEBOUNCE_EN: when defined, each key gets a 2^DEBOUNCE_BITS-cycle debouncer
module squash_input_conditioner #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int RESET_HOLD    = 8
) (
    input logic                          wb_clk_i,
    input logic                          wb_rst_i,
    squash_input_conditioner_if.slave    io
);
    typedef enum logic [1:0] {HOLD, WAIT_READY, RUN} state_t;
    // bit order {gpio, down, up, new_game, pause, ext}; pads idle high, gpio idle low
    localparam logic [5:0] SYNC_RST  = 6'b01_1111;
    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);
    if (RESET_HOLD < 1 || RESET_HOLD > 255 || DEBOUNCE_BITS < 1) begin : g_bad_param
        $error("squash_input_conditioner: parameter out of range");
    end
    logic [5:0] s1_q, s2_q;
    logic [3:0] key_s, stable_q, stable_d;
    logic [1:0] prev_q, pulse;
    logic       ext_s, gpio_s, dr_q;
    logic [7:0] hold_q, hold_d;
    state_t     state_q, state_d;
    assign ext_s  = s2_q[0];
    assign gpio_s = s2_q[5];
    assign key_s  = ~s2_q[4:1];
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q <= SYNC_RST;
            s2_q <= SYNC_RST;
        end else begin
            s1_q <= {io.gpio_ready, io.down_key_n, io.up_key_n, io.new_game_n, io.pause_n, io.ext_reset_n};
            s2_q <= s1_q;
        end
    end
`ifdef SQUASH_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] cnt_q [4];
    logic [DEBOUNCE_BITS-1:0] cnt_d [4];
    // a change is taken only once the counter has seen it on every cycle up to all-ones
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (key_s[i] != stable_q[i]) begin
                if (&cnt_q[i]) stable_d[i] = key_s[i];
                else cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
            end
        end
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) cnt_q <= '{default: '0};
        else cnt_q <= cnt_d;
    end
`else
    assign stable_d = key_s;
`endif
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stable_q <= '0;
            prev_q   <= '0;
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q[1:0];
        end
    end
    // a key already high when reset releases has prev_q set, so it never strobes
    assign pulse = stable_q[1:0] & ~prev_q & {2{~dr_q}};
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            HOLD: begin
                if (ext_s) begin
                    hold_d = hold_q + 8'd1;
                    if (hold_q == HOLD_LAST) state_d = WAIT_READY;
                end
            end
            WAIT_READY: state_d = !ext_s ? HOLD : gpio_s ? RUN : WAIT_READY;
            RUN:        state_d = (!ext_s || !gpio_s) ? HOLD : RUN;
            default:    state_d = HOLD;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= HOLD;
            hold_q  <= '0;
            dr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dr_q    <= state_d != RUN;
        end
    end
    assign io.design_reset       = dr_q;
    assign io.debug_design_reset = dr_q;
    assign io.debug_gpio_ready   = gpio_s;
    assign {io.down_o, io.up_o, io.new_game_o, io.pause_o} = stable_q & {4{~dr_q}};
    assign io.pause_pulse    = pulse[0];
    assign io.new_game_pulse = pulse[1];
endmodule

// File: tb/tb_squash_input_conditioner.sv
// tb_squash_input_conditioner: scoreboard bench for squash_input_conditioner
module tb_squash_input_conditioner;
    localparam int DB = 4;
    localparam int RH = 8;
`ifdef SQUASH_DEBOUNCE_EN
    localparam int LAT = 2 + (1 << DB);
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DEB = 1'b0;
`endif
    localparam int M9 = (LAT > 9) ? LAT : 9;
    localparam logic [8:0] RST_V = 9'b110_0000_00;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    squash_input_conditioner_if bus();
    squash_input_conditioner #(.DEBOUNCE_BITS(DB), .RESET_HOLD(RH)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .io(bus.slave)
    );
    logic [8:0] outs;
    assign outs = {bus.design_reset, bus.debug_design_reset, bus.debug_gpio_ready,
                   bus.pause_o, bus.new_game_o, bus.up_o, bus.down_o,
                   bus.pause_pulse, bus.new_game_pulse};
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int vectors = 0;
    int errors  = 0;
    // k = {pause, new_game, up, down} levels, p = {pause_pulse, new_game_pulse}
    function automatic logic [8:0] mk(bit dr, bit g, logic [3:0] k, logic [1:0] p);
        return {dr, dr, g, k, p};
    endfunction
    task automatic drive(logic r, logic ext, logic [3:0] keys, logic g);
        rst = r;
        bus.ext_reset_n = ext;
        {bus.pause_n, bus.new_game_n, bus.up_key_n, bus.down_key_n} = ~keys;
        bus.gpio_ready = g;
    endtask
    task automatic test_reset();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 1'b1, 4'b0000, 1'b1);
            exp_q.push_back(RST_V);
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL reset_hold c=%0d got %b want %b", c, outs, e); end
        end
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 1'b1, 4'b0000, 1'b1);
            exp_q.push_back(mk(c <= 8, c >= 2, 4'b0000, 2'b00));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL reset_release c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    task automatic test_glitch();
        drive(1'b1, 1'b1, 4'b0000, 1'b1);
        exp_q.push_back(RST_V);
        @(posedge clk); #1;
        vectors++; e = exp_q.pop_front();
        if (outs !== e) begin errors++; $display("FAIL glitch_rst got %b want %b", outs, e); end
        for (int c = 1; c <= 18; c++) begin
            drive(1'b0, c != 6, 4'b0000, 1'b1);
            exp_q.push_back(mk(c <= 16, c >= 2, 4'b0000, 2'b00));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL glitch c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    task automatic test_press(int k, int len);
        logic [3:0] sel;
        bit ok, hi;
        sel = 4'b1000 >> k;
        ok = !DEB || len >= (1 << DB);
        for (int c = 1; c <= len + LAT + 2; c++) begin
            drive(1'b0, 1'b1, (c <= len) ? sel : 4'b0000, 1'b1);
            hi = ok && c >= LAT && c <= len + LAT - 1;
            exp_q.push_back(mk(1'b0, 1'b1, hi ? sel : 4'b0000, (hi && c == LAT) ? sel[3:2] : 2'b00));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL press k=%0d len=%0d c=%0d got %b want %b", k, len, c, outs, e); end
        end
    endtask
    task automatic test_back_to_back();
        bit p, n;
        for (int c = 1; c <= 25 + LAT + 2; c++) begin
            drive(1'b0, 1'b1, {c <= 20, c <= 25, 2'b00}, 1'b1);
            p = c >= LAT && c <= 20 + LAT - 1;
            n = c >= LAT && c <= 25 + LAT - 1;
            exp_q.push_back(mk(1'b0, 1'b1, {p, n, 2'b00}, {2{c == LAT}}));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL dual_press c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    task automatic test_gpio_drop();
        int d, p;
        bit dr, g, hi;
        d = LAT + 3;
        p = d + 14;
        for (int c = 1; c <= p + LAT + 2; c++) begin
            drive(1'b0, 1'b1, (c <= p) ? 4'b1010 : 4'b0000, !(c >= d && c < d + 4));
            dr = c >= d + 2 && c <= d + 10;
            g  = !(c >= d + 1 && c <= d + 4);
            hi = c >= LAT && c <= p + LAT - 1 && !dr;
            exp_q.push_back(mk(dr, g, hi ? 4'b1010 : 4'b0000, {c == LAT, 1'b0}));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL gpio_drop c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    task automatic test_ext_drop();
        for (int c = 1; c <= 16; c++) begin
            drive(1'b0, c > 3, 4'b0000, 1'b1);
            exp_q.push_back(mk(c >= 3 && c <= 13, 1'b1, 4'b0000, 2'b00));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL ext_drop c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    task automatic test_mid_reset();
        bit hi;
        for (int c = 1; c <= LAT + 1; c++) begin
            drive(1'b0, 1'b1, 4'b1000, 1'b1);
            exp_q.push_back(mk(1'b0, 1'b1, {c >= LAT, 3'b000}, {c == LAT, 1'b0}));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL mid_pre c=%0d got %b want %b", c, outs, e); end
        end
        drive(1'b1, 1'b1, 4'b1000, 1'b1);
        exp_q.push_back(RST_V);
        @(posedge clk); #1;
        vectors++; e = exp_q.pop_front();
        if (outs !== e) begin errors++; $display("FAIL mid_rst got %b want %b", outs, e); end
        for (int c = 1; c <= M9 + 3; c++) begin
            drive(1'b0, 1'b1, 4'b1000, 1'b1);
            hi = c >= M9;
            exp_q.push_back(mk(c <= 8, c >= 2, {hi, 3'b000}, {c == LAT && LAT >= 9, 1'b0}));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL mid_release c=%0d got %b want %b", c, outs, e); end
        end
        for (int c = 1; c <= LAT + 2; c++) begin
            drive(1'b0, 1'b1, 4'b0000, 1'b1);
            exp_q.push_back(mk(1'b0, 1'b1, {c <= LAT - 1, 3'b000}, 2'b00));
            @(posedge clk); #1;
            vectors++; e = exp_q.pop_front();
            if (outs !== e) begin errors++; $display("FAIL mid_keyup c=%0d got %b want %b", c, outs, e); end
        end
    endtask
    initial begin
        test_reset();
        test_glitch();
        test_press(0, 10);
        test_press(0, 20);
        test_press(0, 15);
        test_press(0, 16);
        test_press(1, 20);
        test_press(2, 20);
        test_press(3, 1);
        test_press(3, 20);
        test_back_to_back();
        test_gpio_drop();
        test_ext_drop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/squash_input_conditioner.md
# squash_input_conditioner

Input front end for the solo squash game core. It takes the raw active-low pad inputs (`ext_reset_n`, `pause_n`, `new_game_n`, `up_key_n`, `down_key_n`) and the LA `gpio_ready` flag, and synchronises and debounces them. It also sequences the game's design reset. The game core consumes clean active-high key levels and single-cycle press pulses. It sits in the user project wrapper between `io_in`/`la_data_in` and the game core.

## Interface
- `DEBOUNCE_BITS`, default 16: debounce counter width; a key change is accepted after 2^DEBOUNCE_BITS consecutive differing cycles.
- `RESET_HOLD`, default 8, range 1..255: cycles `ext_reset_n` must be continuously high before reset release is allowed.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `ext_reset_n`, `pause_n`, `new_game_n`, `up_key_n`, `down_key_n` in 1 each: raw asynchronous pad inputs, low = asserted.
- `gpio_ready` in 1: firmware "GPIOs configured" flag, treated as asynchronous.
- `design_reset` out 1: reset to the game core, high = in reset.
- `pause_o`, `new_game_o`, `up_o`, `down_o` out 1 each: debounced key levels, high = pressed.
- `pause_pulse`, `new_game_pulse` out 1 each: one-cycle press strobes.
- `debug_design_reset` out 1: copy of `design_reset`.
- `debug_gpio_ready` out 1: synchronised `gpio_ready`.

## Operation
**Synchronisers**
- Each of the six inputs passes through a 2-flop synchroniser.
- On reset, the `_n` synchroniser flops load 1 (released) and the `gpio_ready` flops load 0.

**Debouncers** (one per key: pause, new_game, up, down)
- State is a `stable` bit (reset 0) and a counter (reset 0).
- Synced value (inverted to active-high) equals `stable`: counter clears.
- Synced value differs and counter ≠ all-ones: counter increments.
- Synced value differs and counter = all-ones: `stable` takes the new value and the counter clears.
- Key outputs are `stable` ANDed with `!design_reset`.

**Pulses**
- A strobe is high for exactly one cycle when `stable` goes 0→1 while `design_reset` = 0.
- No strobe is generated on release.
- A key held through reset release does not generate a strobe.

**Reset sequencer FSM**, states HOLD, WAIT_READY, RUN; reset state is HOLD.
- HOLD:
  - 8-bit counter increments while synced `ext_reset_n` = 1 and clears to 0 while it is 0.
  - When the counter = RESET_HOLD−1 and `ext_reset_n` = 1, go to WAIT_READY.
- WAIT_READY:
  - Synced `ext_reset_n` = 0: go to HOLD and clear the counter.
  - Otherwise, synced `gpio_ready` = 1: go to RUN.
- RUN:
  - Synced `ext_reset_n` = 0 or synced `gpio_ready` = 0: go to HOLD and clear the counter.
  - `ext_reset_n` takes priority when both events occur together.
- `design_reset` is a dedicated flop equal to (state ≠ RUN) and has no combinational path to the output. Reset value is 1.

**Reset mid-operation**
- `wb_rst_i` returns every flop to its reset value on the next edge, regardless of FSM state or counter values.

## Timing
- Reset values:
  - `design_reset` and `debug_design_reset` = 1.
  - All other outputs = 0.
- Key latency:
  - Raw edge to synced value: 2 edges.
  - Synced value to `stable`: 2^DEBOUNCE_BITS further edges.
  - Total: 2 + 2^DEBOUNCE_BITS edges.
  - The strobe is asserted in the same cycle `stable` rises.
- Any bounce shorter than 2^DEBOUNCE_BITS cycles is fully rejected.
- Reset release latency, with `ext_reset_n` high and `gpio_ready` high from reset deassert: `design_reset` falls after edge RESET_HOLD+1.
- Loss of `gpio_ready` or `ext_reset_n` in RUN: `design_reset` rises 3 edges after the raw input change (2 synchroniser edges + 1 FSM edge).

## Configuration
- Macro: `SQUASH_DEBOUNCE_EN`.
- Defined: debouncers are built as described above.
- Undefined:
  - Debouncers and counters are omitted.
  - `stable` is the inverted synced value, registered once, giving 3 edges raw-to-output.
  - Strobe, gating and reset sequencer behaviour are unchanged.
  - `DEBOUNCE_BITS` is ignored.

## Test plan
Bench settings: DEBOUNCE_BITS=4, RESET_HOLD=8.
- Release `wb_rst_i` with `ext_reset_n`=1 and `gpio_ready`=1 → `design_reset`=1 through edge 8, 0 after edge 9; `debug_gpio_ready`=1 after edge 2.
- In HOLD, drive a one-cycle low glitch on `ext_reset_n` at counter=5 → counter restarts; `design_reset` falls 9 edges after the glitch ends (8 HOLD + 1 WAIT_READY, after sync).
- In RUN, hold `pause_n` low for 10 cycles then high → `pause_o` and `pause_pulse` stay 0. Hold `pause_n` low for 20 cycles → `pause_o` rises after edge 18 (counted from the fall), `pause_pulse` is high for exactly that cycle, and `pause_o` falls 18 edges after release.
- Press `pause_n` and `new_game_n` on the same cycle → both strobes assert on the same cycle; releasing either produces no strobe.
- In RUN with `up_key_n` held pressed, drop `gpio_ready` → `design_reset`=1 three edges later, `up_o` forced to 0. Restore `gpio_ready` → after the HOLD/WAIT_READY sequence `up_o`=1 with no strobe.
- Without `SQUASH_DEBOUNCE_EN`: drive `down_key_n` low for 1 cycle → `down_o` is high for exactly 1 cycle, 3 edges later.
